// File: rtl/hazard_ctrl_pkg.sv
// Shared decode constants, forwarding select codes and the per-stage
// instruction summary consumed by the hazard/forwarding logic.
package hazard_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  typedef enum logic [1:0] {
    FW_OWN     = 2'd0,
    FW_E2M_ALU = 2'd1,
    FW_M2W_ALU = 2'd2,
    FW_M2W_MEM = 2'd3
  } fw_sel_e;

  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_LOAD = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew;
    logic       is_load;
    logic       is_store;
    logic       is_md_start;
    logic       is_md_div;
    logic       is_md_use;
  } instr_info_t;

  localparam instr_info_t NO_PRODUCER = '0;

endpackage

// File: rtl/hazard_ctrl_instr_class.sv
// Pure decode of one instruction word into its register usage, Tuse/Tnew
// timing and multiply/divide interaction flags.
module hazard_ctrl_instr_class
  import hazard_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output instr_info_t info
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op           = instr[31:26];
  assign funct        = instr[5:0];
  assign rd           = instr[15:11];
  assign unused_shamt = ^instr[10:6];

  always_comb begin
    info         = NO_PRODUCER;
    info.rs      = instr[25:21];
    info.rt      = instr[20:16];
    info.wreg    = REG_ZERO;
    info.tuse_rs = TUSE_NONE;
    info.tuse_rt = TUSE_NONE;
    info.tnew    = TNEW_NONE;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_MFHI, FN_MFLO: begin
            info.wreg      = rd;
            info.tuse_rs   = TUSE_1;
            info.tuse_rt   = TUSE_1;
            info.tnew      = TNEW_ALU;
            info.is_md_use = (funct == FN_MFHI) || (funct == FN_MFLO);
          end
          FN_JR: info.tuse_rs = TUSE_0;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            info.tuse_rs     = TUSE_1;
            info.tuse_rt     = TUSE_1;
            info.is_md_start = 1'b1;
            info.is_md_div   = (funct == FN_DIV) || (funct == FN_DIVU);
            info.is_md_use   = 1'b1;
          end
          FN_MTHI, FN_MTLO: begin
            info.tuse_rs   = TUSE_1;
            info.is_md_use = 1'b1;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDIU, OP_LUI: begin
        info.wreg    = instr[20:16];
        info.tuse_rs = TUSE_1;
        info.tnew    = TNEW_ALU;
      end
      OP_LW: begin
        info.wreg    = instr[20:16];
        info.tuse_rs = TUSE_1;
        info.tnew    = TNEW_LOAD;
        info.is_load = 1'b1;
      end
      OP_SW: begin
        info.tuse_rs  = TUSE_1;
        info.tuse_rt  = TUSE_2;
        info.is_store = 1'b1;
      end
      OP_BEQ: begin
        info.tuse_rs = TUSE_0;
        info.tuse_rt = TUSE_0;
      end
      // jal's return address rides in the ALUout field, so it behaves as an ALU producer
      OP_JAL: begin
        info.wreg = REG_RA;
        info.tnew = TNEW_ALU;
      end
      OP_J: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: stall generation, forwarding-mux selects and the
// multiply/divide busy counter for the five-stage I/D/E/M/W datapath.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] D_instr,
  input  logic [31:0] E_instr,
  input  logic [31:0] M_instr,
  input  logic [31:0] W_instr,
  output logic        PCfreeze,
  output logic        setNOP,
  output logic [31:0] D_FMUX1_slt,
  output logic [31:0] D_FMUX2_slt,
  output logic [31:0] E_FMUX1_slt,
  output logic [31:0] E_FMUX2_slt,
  output logic [31:0] M_FUMX_slt,
  output logic        md_busy
);

  instr_info_t d_i, e_i, m_i, w_i;
  logic [CNT_W-1:0] md_cnt;
  logic             cnt_nz;
  logic             data_stall;
  logic             md_stall;
  logic             unused_info;

  hazard_ctrl_instr_class u_dec_d (.instr(D_instr), .info(d_i));
  hazard_ctrl_instr_class u_dec_e (.instr(E_instr), .info(e_i));
  hazard_ctrl_instr_class u_dec_m (.instr(M_instr), .info(m_i));
  hazard_ctrl_instr_class u_dec_w (.instr(W_instr), .info(w_i));

  assign unused_info = ^{d_i, e_i, m_i, w_i};

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  function automatic logic [1:0] tnew_in_m(input logic [1:0] tnew);
    return (tnew == TNEW_NONE) ? TNEW_NONE : tnew - 2'd1;
  endfunction

  // Only the youngest producer of a register is consulted; an older one is shadowed.
  function automatic logic operand_stall(input logic [4:0] src, input logic [1:0] tuse,
                                         input instr_info_t e, input instr_info_t m);
    logic hit;
    hit = 1'b0;
    if (src != REG_ZERO) begin
      if (e.wreg == src)      hit = (tuse < e.tnew);
      else if (m.wreg == src) hit = (tuse < tnew_in_m(m.tnew));
    end
    return hit;
  endfunction

  function automatic fw_sel_e pick_fw(input logic [4:0] src, input instr_info_t younger,
                                      input instr_info_t m, input instr_info_t w);
    fw_sel_e sel;
    sel = FW_OWN;
    if (src != REG_ZERO) begin
      if (younger.wreg == src)  sel = FW_OWN;
      else if (m.wreg == src)   sel = (tnew_in_m(m.tnew) == TNEW_NONE) ? FW_E2M_ALU : FW_OWN;
      else if (w.wreg == src)   sel = w.is_load ? FW_M2W_MEM : FW_M2W_ALU;
    end
    return sel;
  endfunction

  function automatic logic [31:0] sel_word(input logic en, input fw_sel_e sel);
    return en ? {30'd0, sel} : 32'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset)                md_cnt <= '0;
    else if (e_i.is_md_start)  md_cnt <= e_i.is_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else                       md_cnt <= sat_dec(md_cnt);
  end

  assign cnt_nz = (md_cnt != '0);

  always_comb begin
    data_stall  = operand_stall(d_i.rs, d_i.tuse_rs, e_i, m_i) |
                  operand_stall(d_i.rt, d_i.tuse_rt, e_i, m_i);
    md_stall    = d_i.is_md_use & (cnt_nz | e_i.is_md_start);
    PCfreeze    = reset & (data_stall | md_stall);
    setNOP      = reset & (data_stall | md_stall);
    md_busy     = reset & cnt_nz;
    D_FMUX1_slt = sel_word(reset, pick_fw(d_i.rs, e_i, m_i, w_i));
    D_FMUX2_slt = sel_word(reset, pick_fw(d_i.rt, e_i, m_i, w_i));
    E_FMUX1_slt = sel_word(reset, pick_fw(e_i.rs, NO_PRODUCER, m_i, w_i));
    E_FMUX2_slt = sel_word(reset, pick_fw(e_i.rt, NO_PRODUCER, m_i, w_i));
    M_FUMX_slt  = sel_word(reset & m_i.is_store, pick_fw(m_i.rt, NO_PRODUCER, NO_PRODUCER, w_i));
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the five-stage datapath (I/D/E/M/W).
- Inspects the instructions held in D, E, M and W each cycle. Generates PCfreeze/setNOP stall controls and the forwarding-mux selects consumed by the D, E and M stages.
- Holds the only sequential state in the control path: a multiply/divide busy counter that stalls HI/LO-class instructions while the MD unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles after mult/multu leaves E.
- DIV_CYCLES, 10, busy cycles after div/divu leaves E.
- CNT_W, 4, busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- D_instr  in  32  instruction in D (I2D output).
- E_instr  in  32  instruction in E (D2E output).
- M_instr  in  32  instruction in M (E2M output).
- W_instr  in  32  instruction in W (M2W output).
- PCfreeze  out  1  hold PC.
- setNOP  out  1  freeze I2D and bubble D2E.
- D_FMUX1_slt  out  32  D rs operand select.
- D_FMUX2_slt  out  32  D rt operand select.
- E_FMUX1_slt  out  32  E rs operand select.
- E_FMUX2_slt  out  32  E rt operand select.
- M_FUMX_slt  out  32  M store-data select.
- md_busy  out  1  MD counter nonzero.

Behaviour:
- Select encoding (low 2 bits; bits 31:2 always 0):
  - 0 = stage's own value (GRF read, with internal W bypass, or pipeline register).
  - 1 = E2M_ALUout.
  - 2 = M2W_ALUout.
  - 3 = M2W_MEMout.
- Instruction classes:
  - cal_r (addu, subu, and, or, slt, sll, mfhi, mflo): write rd, Tnew=1.
  - cal_i (ori, addiu, lui): write rt, Tnew=1.
  - lw: write rt, Tnew=2.
  - jal: write $31, Tnew=1; PC+8 travels in the ALUout field.
  - sw, beq, j, jr, mult*, div*, mthi, mtlo, nop: no write.
- Tuse values:
  - beq rs/rt = 0; jr rs = 0.
  - cal_r rs/rt = 1; cal_i rs = 1; lw rs = 1.
  - sw rs = 1, sw rt = 2.
  - mult/div rs/rt = 1; mthi/mtlo rs = 1.
  - Unused operand Tuse = 3 (never stalls).
- Remaining Tnew: E stage = Tnew; M stage = max(Tnew-1, 0); W stage = 0.
- Data stall: any D operand with a nonzero register number equal to the write register of E or M, where Tuse < remaining Tnew of that producer. The youngest matching producer decides.
- MD stall: D holds mult*/div*/mfhi/mflo/mthi/mtlo AND (md_busy OR E_instr is mult*/div*).
- Stall output: PCfreeze = setNOP = data stall OR MD stall. Combinational from the stage instructions, zero latency.
- Forwarding is combinational. Register 0 is never forwarded.
- Priority is youngest producer first. A match only forwards when the producer's remaining Tnew is 0 (otherwise the stall covers it).
  - D selects: M producer, non-load → 1. W producer → 2 (ALU class) or 3 (lw). Else 0.
  - E selects: same rule as D selects.
  - M_FUMX (rt of sw in M): W producer → 2 or 3. Else 0.
- MD counter update:
  - When E_instr is mult/multu, the counter loads MULT_CYCLES at the next edge.
  - When E_instr is div/divu, the counter loads DIV_CYCLES at the next edge.
  - Otherwise it decrements by 1 if nonzero; it saturates at 0.
  - A load overrides a decrement. Back-to-back MD ops are impossible, because the MD stall bubbles E.
  - md_busy = (counter != 0).
- Reset:
  - reset low at a clock edge clears the counter to 0.
  - While reset is low, PCfreeze, setNOP and all selects are forced to 0 and md_busy reads 0.
  - Reset asserted mid-MD-operation aborts the busy window in the same edge.
- Simultaneous data stall and MD stall give a single stall. There is no double-bubble effect; the outputs are just ORed.

Decomposition:
- def.v gains:
  - opcode/funct constants;
  - select codes (FW_OWN=0, FW_E2M_ALU=1, FW_M2W_ALU=2, FW_M2W_MEM=3);
  - Tuse/Tnew constants.
- Sub-module instr_class:
  - Pure decode of one instruction into rs, rt, write register, Tuse_rs, Tuse_rt, Tnew, is_load, is_md_start, is_md_use.
  - Instantiated 4 times (D/E/M/W).
- hazard_ctrl holds the compare/priority logic and the MD counter.

Test Plan:
- E = lw $8, D = addu $9,$8,$10 → PCfreeze=setNOP=1 for 1 cycle. Next cycle lw is in M: still stalled (Tnew 1 > Tuse 1? no). With M=lw and Tnew_rem=1 equal to Tuse 1, no stall; the W-stage forward then gives E_FMUX1_slt=3.
- M = addu $8, D = beq $8,$0 → no stall, D_FMUX1_slt=1. Change M→E: stall 1 cycle, then D_FMUX1_slt=1.
- W = lw $5, M = sw $5 → M_FUMX_slt=3, no stall. W = ori $5 instead → M_FUMX_slt=2.
- E = mult then D = mflo (after bubble) → stall while E is mult plus 5 busy cycles. md_busy is high 5 cycles; mflo enters E on the cycle md_busy falls.
- Same as above with div → md_busy high 10 cycles. Pull reset low at busy cycle 4 → counter 0 and stall released next cycle.
- Producer writes $0 (addu $0,…) with consumer reading $0 → all selects 0, no stall. Two producers of $8 in M and W → E_FMUX selects 1 (youngest).
